// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The requester drives the start handshake and operands; the adder returns serial and parallel results.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b,
        input  s, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b,
        output s, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder plus carry flop, LSB-first, with a
// start/busy/done handshake, a parallel result and carry/overflow flags.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    serial_addsub_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;

    // Single full-adder slice over the current LSBs and the carry flop.
    always_comb begin
        fa_s     = ra[0] ^ rb[0] ^ carry;
        fa_c     = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
        res_next = {fa_s, res[WIDTH-1:1]};
    end

    assign bus.s    = (state == RUN) ? fa_s : 1'b0;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

    // Subtraction is A + ~B + 1: invert B at load and seed the carry with mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        ra     <= bus.a;
                        rb     <= bus.b ^ {WIDTH{bus.mode}};
                        res    <= '0;
                        carry  <= bus.mode;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    res   <= res_next;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    // On the MSB slice the carry flop holds the carry into the MSB.
                    if (cnt == LAST_BIT) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        sum_q  <= res_next;
                        cout_q <= fa_c;
                        ovf_q  <= carry ^ fa_c;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with an arithmetic reference model checked every cycle.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    logic enable;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 running bit bi, 2 result ready.
    int          ph = 0;
    int          bi = 0;
    logic [W-1:0] m_res = '0;
    logic        m_c = 1'b0;
    logic        m_v = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf = 1'b0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        int ua, ub, sa, sb, exact;
        started = 1'b1;
        if (rst) begin
            ph = 0; bi = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (enable) begin
            if (ph == 1) begin
                bi++;
                if (bi == int'(W)) begin
                    ph = 2; m_sum = m_res; m_cout = m_c; m_ovf = m_v;
                end
            end else if (bus.start) begin
                ua = int'(bus.a);
                ub = int'(bus.b);
                sa = $signed(bus.a);
                sb = $signed(bus.b);
                exact = bus.mode ? (sa - sb) : (sa + sb);
                m_res = W'(bus.mode ? (ua - ub) : (ua + ub));
                m_c   = bus.mode ? (ua >= ub) : ((ua + ub) >= (1 << W));
                m_v   = (exact > (1 << (W - 1)) - 1) || (exact < -(1 << (W - 1)));
                ph = 1; bi = 0;
            end else begin
                ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(bus.busy), 32'(ph == 1));
            chk("done", 32'(bus.done), 32'(ph == 2));
            chk("s",    32'(bus.s),    32'((ph == 1) ? m_res[bi] : 1'b0));
            chk("sum",  32'(bus.sum),  32'(m_sum));
            chk("cout", 32'(bus.cout), 32'(m_cout));
            chk("ovf",  32'(bus.ovf),  32'(m_ovf));
        end
    end

    // Issue one operation from a negedge and follow it until Done (or a planted reset).
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm,
                      input int stall_at, input int stall_len, input int ign_at, input int rst_at,
                      output int n, output logic [W-1:0] seq, output bit gapless);
        bit e;
        int k;
        bus.start = 1'b1; bus.a = ta; bus.b = tb; bus.mode = tm;
        n = 0; k = 0; seq = '0; gapless = 1'b1;
        for (int i = 0; i < 40; i++) begin
            e = enable;
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (rst) begin
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
                chk("rst_sum",  32'(bus.sum),  32'd0);
                chk("rst_s",    32'(bus.s),    32'd0);
                rst = 1'b0;
                break;
            end
            if (bus.busy && e && k < int'(W)) begin
                seq[k] = bus.s;
                k++;
            end
            if (!bus.busy && !bus.done) gapless = 1'b0;
            if (bus.done) break;
            if (n == stall_at) enable = 1'b0;
            if (n == stall_at + stall_len) enable = 1'b1;
            if (n == ign_at) begin
                bus.start = 1'b1; bus.a = '0; bus.b = '0;
            end
            if (n == rst_at) rst = 1'b1;
        end
    endtask

    initial begin
        int n;
        logic [W-1:0] seq;
        bit gl;

        rst = 1'b1; enable = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("reset_sum", 32'(bus.sum), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0x5A + 0x3C
        op(8'h5A, 8'h3C, 1'b0, -1, 0, -1, -1, n, seq, gl);
        chk("add_lat", 32'(n), 32'd9);
        chk("add_sum", 32'(bus.sum), 32'h96);
        chk("add_cout", 32'(bus.cout), 32'd0);
        chk("add_ovf", 32'(bus.ovf), 32'd1);
        chk("add_seq", 32'(seq), 32'h96);
        repeat (2) @(negedge clk);
        chk("idle_hold_sum", 32'(bus.sum), 32'h96);

        // Subtractions
        op(8'h10, 8'h20, 1'b1, -1, 0, -1, -1, n, seq, gl);
        chk("sub1_sum", 32'(bus.sum), 32'hF0);
        chk("sub1_cout", 32'(bus.cout), 32'd0);
        chk("sub1_ovf", 32'(bus.ovf), 32'd0);
        repeat (1) @(negedge clk);
        op(8'h80, 8'h01, 1'b1, -1, 0, -1, -1, n, seq, gl);
        chk("sub2_sum", 32'(bus.sum), 32'h7F);
        chk("sub2_cout", 32'(bus.cout), 32'd1);
        chk("sub2_ovf", 32'(bus.ovf), 32'd1);
        repeat (1) @(negedge clk);

        // Wrap then back-to-back start in the Done cycle
        op(8'hFF, 8'h01, 1'b0, -1, 0, -1, -1, n, seq, gl);
        chk("wrap_sum", 32'(bus.sum), 32'h00);
        chk("wrap_cout", 32'(bus.cout), 32'd1);
        chk("wrap_ovf", 32'(bus.ovf), 32'd0);
        op(8'h01, 8'h01, 1'b0, -1, 0, -1, -1, n, seq, gl);
        chk("b2b_lat", 32'(n), 32'd9);
        chk("b2b_sum", 32'(bus.sum), 32'h02);
        chk("b2b_gapless", 32'(gl), 32'd1);
        repeat (2) @(negedge clk);

        // Enable low for three cycles after bit 3
        op(8'h5A, 8'h3C, 1'b0, 4, 3, -1, -1, n, seq, gl);
        chk("stall_lat", 32'(n), 32'd12);
        chk("stall_sum", 32'(bus.sum), 32'h96);
        chk("stall_ovf", 32'(bus.ovf), 32'd1);
        chk("stall_seq", 32'(seq), 32'h96);
        repeat (2) @(negedge clk);

        // Start pulsed during RUN is ignored
        op(8'h5A, 8'h3C, 1'b0, -1, 0, 3, -1, n, seq, gl);
        chk("ign_lat", 32'(n), 32'd9);
        chk("ign_sum", 32'(bus.sum), 32'h96);
        @(negedge clk);
        chk("ign_single_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);

        // Reset during bit 4, then a fresh operation
        op(8'h5A, 8'h3C, 1'b0, -1, 0, -1, 5, n, seq, gl);
        chk("rst_at", 32'(n), 32'd6);
        op(8'h01, 8'h02, 1'b0, -1, 0, -1, -1, n, seq, gl);
        chk("post_rst_lat", 32'(n), 32'd9);
        chk("post_rst_sum", 32'(bus.sum), 32'h03);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor for the sequential-arithmetic datapath. It loads two WIDTH-bit operands in parallel on a start handshake and processes them LSB-first, one bit per enabled clock cycle, through a single full-adder and a carry flip-flop. While running it emits each sum bit on a serial output. It presents the parallel result with carry-out and signed overflow alongside a one-cycle done pulse. Generalises the single-bit serial adder with operand width, subtract mode, a start/busy/done handshake and status flags.

## Interface
- WIDTH, 8: operand and result width in bits, ≥ 2.
- CNT_W, $clog2(WIDTH): bit-counter width (derived; do not override).

- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; takes effect on the rising edge where it is high.
- Enable  in  1  clock enable; when low, all state holds.
- Start  in  1  request to begin an operation; sampled only in IDLE or DONE with Enable=1.
- Mode  in  1  0 = A+B, 1 = A−B; sampled with Start.
- A  in  WIDTH  operand A; sampled with Start.
- B  in  WIDTH  operand B; sampled with Start.
- S  out  1  current serial sum bit, LSB-first; 0 outside RUN.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse in DONE.
- Sum  out  WIDTH  parallel result; holds from DONE until the next accepted Start.
- Cout  out  1  carry out of MSB (subtract: 1 = no borrow).
- Ovf  out  1  two's-complement overflow.

## Operation
- Reset: state=IDLE; S, Busy, Done, Sum, Cout and Ovf are 0; counter, carry and shift registers are cleared.
- IDLE: on Start and Enable, latch A into shift register ra and B^{WIDTH{Mode}} into rb. Set carry=Mode, counter=0, go to RUN.
- RUN, with Enable=1, each cycle:
  - S = ra[0]^rb[0]^carry (combinational from registered state).
  - Carry ← majority(ra[0], rb[0], carry).
  - Shift S into result register from MSB side; shift ra and rb right.
  - Counter increments.
  - At counter=WIDTH−1, record carry-into-MSB for overflow, then go to DONE.
- DONE (one cycle): Done=1. Sum = result register, Cout = final carry, Ovf = carry-into-MSB ^ final carry.
  - With Start and Enable: accept new operands back-to-back and go to RUN.
  - Otherwise go to IDLE.
- Start during RUN is ignored; operands are not re-sampled.
- Enable=0 in any state: no transition. State, counter, carry, shift registers and outputs hold. A Done pulse is held while frozen in DONE. S keeps its combinational value.
- Sum, Cout and Ovf update only on entry to DONE. Between operations, IDLE keeps the last result.
- Arithmetic is modulo 2^WIDTH. Cout and Ovf are valid for both unsigned and signed interpretation.

## Timing
- With Start accepted at edge t and Enable held high: Busy is 1 for cycles t+1 … t+WIDTH, and Done is 1 in cycle t+WIDTH+1.
- Latency from Start to Done is WIDTH+1 cycles. Each Enable-low cycle during RUN/DONE adds one cycle.
- S bit i is valid in cycle t+1+i (plus stall cycles).
- Back-to-back operation: Start in the DONE cycle gives a WIDTH+1-cycle period with no idle gap.
- Reset mid-operation: after the reset edge, state=IDLE and all outputs are 0. The partial result is discarded, and no Done occurs.
- Reset and Start in the same cycle: Reset wins.

## Test plan
- Add, WIDTH=8: A=0x5A, B=0x3C, Mode=0 → S sequence 0,1,1,0,1,0,0,1; Done 9 cycles after Start; Sum=0x96, Cout=0, Ovf=1.
- Subtract: A=0x10, B=0x20, Mode=1 → Sum=0xF0, Cout=0, Ovf=0. Then A=0x80, B=0x01, Mode=1 → Sum=0x7F, Cout=1, Ovf=1.
- Wrap and back-to-back: A=0xFF, B=0x01 add, followed by Start in the DONE cycle with A=0x01, B=0x01 → first Sum=0x00, Cout=1, Ovf=0. Second Done exactly 9 cycles later with Sum=0x02, and Busy never drops between the two operations.
- Stall: Enable low for 3 cycles after bit 3 of 0x5A+0x3C → Done at cycle 12 after Start; same Sum, flags and S sequence; all state frozen during the stall.
- Start ignored: pulse Start with A=0x00, B=0x00 during RUN of 0x5A+0x3C → result is still 0x96, with a single Done.
- Reset mid-op: Reset high during bit 4 → Busy, Done, Sum and S are 0 the next cycle. A subsequent 0x01+0x02 gives Sum=0x03 after 9 cycles.
